// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state encoding, counter width and address check for mem_responder
package mem_resp_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int LAT_W = 4;
  localparam int DEF_DEPTH_WORDS = 64;
  function automatic logic adr_bad(input logic [31:0] adr, input int depth);
    return adr[1:0] != 2'b00 || adr >= 32'(4 * depth);
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU-to-memory request/response bus, MemErr present only with MEM_RESP_ERR_EN
interface mem_responder_if;
  logic        MemReq;
  logic        MemW;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
`ifdef MEM_RESP_ERR_EN
  logic        MemErr;
  modport master(output MemReq, MemW, Adr, WriteData, input ReadData, MemReady, MemErr);
  modport slave(input MemReq, MemW, Adr, WriteData, output ReadData, MemReady, MemErr);
`else
  modport master(output MemReq, MemW, Adr, WriteData, input ReadData, MemReady);
  modport slave(input MemReq, MemW, Adr, WriteData, output ReadData, MemReady);
`endif
endinterface

// File: rtl/mem_array.sv
// mem_array: synchronous-write, synchronous-read word RAM
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  localparam int IW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (we) mem[index] <= wdata;
    rdata <= mem[index];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder with MemReady handshake, optional MemErr via MEM_RESP_ERR_EN
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY = 2
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  logic [1:0]       state;
  logic [LAT_W-1:0] cnt;
  logic [IW-1:0]    idx_q, idx;
  logic             wr_q, wr, err_q, err, accept, commit, done;
  logic [31:0]      wdata_q, arr_rdata, rd_q, rd_now;
  assign accept = state == IDLE && bus.MemReq;
  // the edge entering DONE is the commit point; with zero latency that is the accept edge itself
  assign commit = (accept && LATENCY == 0) || (state == WAIT && cnt == LAT_W'(1));
  assign idx = accept ? bus.Adr[IW+1:2] : idx_q;
  assign wr = accept ? bus.MemW : wr_q;
`ifdef MEM_RESP_ERR_EN
  assign err = accept ? adr_bad(bus.Adr, DEPTH_WORDS) : err_q;
  assign bus.MemErr = done && err_q;
`else
  assign err = 1'b0;
`endif
  assign done = state == DONE;
  assign bus.MemReady = done;
  assign rd_now = err_q ? '0 : arr_rdata;
  assign bus.ReadData = done && !wr_q ? rd_now : rd_q;
  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk  (clk),
    .we   (commit && wr && !err),
    .index(idx),
    .wdata(accept ? bus.WriteData : wdata_q),
    .rdata(arr_rdata)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else begin
      if (accept) begin
        idx_q   <= idx;
        wr_q    <= wr;
        err_q   <= err;
        wdata_q <= bus.WriteData;
        cnt     <= LAT_W'(LATENCY);
      end else if (state == WAIT) cnt <= cnt - LAT_W'(1);
      if (done && !wr_q) rd_q <= rd_now;
      state <= commit ? DONE : accept ? WAIT : done ? IDLE : state;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder at LATENCY 2 and 0, MEM_RESP_ERR_EN aware
module tb_mem_responder;
`ifdef MEM_RESP_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q0[$], q1[$];
  logic [31:0] m0 [64];
  logic [31:0] m1 [64];
  logic [31:0] rd_m [2];
  logic e0, e1;
  mem_responder_if b0();
  mem_responder_if b1();
  mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
`ifdef MEM_RESP_ERR_EN
  assign e0 = b0.MemErr;
  assign e1 = b1.MemErr;
`else
  assign e0 = 1'b0;
  assign e1 = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  task automatic mon(input int d, input logic [31:0] rd, input logic er);
    exp_t e;
    int sz;
    sz = d ? q1.size() : q0.size();
    chk($sformatf("pulse_expected_dut%0d", d), 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      e = d ? q1.pop_front() : q0.pop_front();
      chk($sformatf("ready_cycle_dut%0d", d), cyc, e.cyc);
      chk($sformatf("readdata_dut%0d", d), rd, e.rd);
      chk($sformatf("memerr_dut%0d", d), 32'(er), 32'(e.err));
    end
  endtask
  always @(negedge clk) begin
    if (b0.MemReady) mon(0, b0.ReadData, e0);
    if (b1.MemReady) mon(1, b1.ReadData, e1);
  end
  task automatic drive(input int d, input logic rq, input logic w, input logic [31:0] adr, input logic [31:0] wd);
    if (d == 0) begin
      b0.MemReq = rq; b0.MemW = w; b0.Adr = adr; b0.WriteData = wd;
    end else begin
      b1.MemReq = rq; b1.MemW = w; b1.Adr = adr; b1.WriteData = wd;
    end
  endtask
  task automatic wait_ready(input int d);
    int n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 40) begin
      @(negedge clk);
      n++;
      rdy = d ? b1.MemReady : b0.MemReady;
    end
    chk($sformatf("ready_seen_dut%0d", d), 32'(rdy), 32'd1);
  endtask
  task automatic push(input int d, input logic w, input logic [31:0] adr, input logic [31:0] wd);
    exp_t e;
    logic bad;
    int idx;
    bad = ERR && (adr[1:0] != 2'b00 || adr >= 32'h100);
    idx = int'(adr[7:2]);
    e.cyc = cyc + 1 + (d ? 0 : 2);
    e.err = bad;
    e.rd = w ? rd_m[d] : bad ? 32'h0 : d ? m1[idx] : m0[idx];
    if (w && !bad) begin
      if (d) m1[idx] = wd;
      else m0[idx] = wd;
    end
    if (!w) rd_m[d] = e.rd;
    if (d) q1.push_back(e);
    else q0.push_back(e);
  endtask
  task automatic req(input int d, input logic w, input logic [31:0] adr, input logic [31:0] wd);
    @(negedge clk);
    push(d, w, adr, wd);
    drive(d, 1'b1, w, adr, wd);
    wait_ready(d);
    drive(d, 1'b0, 1'b0, adr, wd);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_ready_dut0", 32'(b0.MemReady), 32'd0);
      chk("idle_ready_dut1", 32'(b1.MemReady), 32'd0);
      chk("hold_readdata_dut0", b0.ReadData, rd_m[0]);
      chk("hold_readdata_dut1", b1.ReadData, rd_m[1]);
    end
  endtask
  task automatic b2b();
    exp_t e;
    int c;
    @(negedge clk);
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      e.cyc = c + 1 + 2 * k;
      e.rd = m1[k];
      e.err = 1'b0;
      q1.push_back(e);
    end
    rd_m[1] = m1[2];
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      wait_ready(1);
      if (k < 2) b1.Adr = 32'(4 * (k + 1));
      else b1.MemReq = 1'b0;
    end
  endtask
  task automatic chg();
    @(negedge clk);
    push(0, 1'b0, 32'h20, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h24, 32'hFFFF_FFFF);
    wait_ready(0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask
  task automatic midreset();
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h8, 32'h1234_5678);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rd_m[0] = 32'h0;
    rd_m[1] = 32'h0;
    repeat (2) begin
      @(negedge clk);
      chk("reset_no_ready", 32'(b0.MemReady), 32'd0);
      chk("reset_readdata", b0.ReadData, 32'h0);
    end
    reset = 1'b1;
    idle(4);
  endtask
  initial begin
    rd_m[0] = 32'h0;
    rd_m[1] = 32'h0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("reset_ready_dut0", 32'(b0.MemReady), 32'd0);
    chk("reset_readdata_dut0", b0.ReadData, 32'h0);
    reset = 1'b1;
    idle(10);
    req(1, 1'b1, 32'h0, 32'h1111_0000);
    req(1, 1'b1, 32'h4, 32'h2222_0004);
    req(1, 1'b1, 32'h8, 32'h3333_0008);
    req(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    req(0, 1'b0, 32'h10, 32'h0);
    idle(3);
    b2b();
    idle(2);
    req(0, 1'b1, 32'h20, 32'hCAFE_0020);
    req(0, 1'b1, 32'h24, 32'hBEEF_0024);
    chg();
    req(0, 1'b0, 32'h24, 32'h0);
    idle(2);
    req(0, 1'b1, 32'h8, 32'hA5A5_0008);
    midreset();
    req(0, 1'b0, 32'h8, 32'h0);
    req(0, 1'b1, 32'h0, 32'h0000_0001);
`ifdef MEM_RESP_ERR_EN
    req(0, 1'b1, 32'h102, 32'h7777_0102);
    req(0, 1'b0, 32'h3, 32'h0);
`else
    req(0, 1'b1, 32'h100, 32'h7777_0100);
`endif
    req(0, 1'b0, 32'h0, 32'h0);
    idle(3);
    chk("leftover_dut0", q0.size(), 32'd0);
    chk("leftover_dut1", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
